// File: rtl/sequenciador_pkg.sv
// Shared encodings for the multicycle sequencer: FSM states, opcodes and
// datapath select codes.
package sequenciador_pkg;

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    CARREGA_IR = 3'd1,
    DECODIFICA = 3'd2,
    EXECUTA    = 3'd3,
    ESCRITA    = 3'd4,
    DESVIO     = 3'd5,
    RETIRA     = 3'd6,
    ESPERA     = 3'd7   // also PARADA when halted=1
  } estado_t;

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_IMM_MIN = 4'd6;
  localparam logic [3:0] OP_ALU_MAX = 4'd10;
  localparam logic [3:0] OP_JZ      = 4'd11;
  localparam logic [3:0] OP_J       = 4'd12;
  localparam logic [3:0] OP_HALT    = 4'd13;

  localparam logic [1:0] ULA_B_REG = 2'b00;
  localparam logic [1:0] ULA_B_UM  = 2'b01;
  localparam logic [1:0] ULA_B_IMM = 2'b10;

  localparam logic [1:0] FONTE_ULA = 2'b00;
  localparam logic [1:0] FONTE_IR  = 2'b10;

endpackage

// File: rtl/sequenciador_multiciclo_detector_borda.sv
// Two-flop synchronizer for the raw step key followed by a falling-edge
// detector; emits a single-cycle pulse per press.
module detector_borda (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic entrada_n,
  output logic pulso
);

  logic sinc_1, sinc_2, atrasado;

  // Reset state is "key released" so a held key at reset does not fire.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sinc_1   <= 1'b1;
      sinc_2   <= 1'b1;
      atrasado <= 1'b1;
    end else begin
      sinc_1   <= entrada_n;
      sinc_2   <= sinc_1;
      atrasado <= sinc_2;
    end
  end

  assign pulso = atrasado & ~sinc_2;

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Multicycle control FSM: fetch/decode/execute/writeback sequencing, PC and
// ALU select generation, zero-flag latch and single-step debug hold.
module sequenciador_multiciclo
  import sequenciador_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             step_mode,
  input  logic             step_key_n,
  output logic             esc_ir,
  output logic             esc_cp,
  output logic             esc_cond_cp,
  output logic [1:0]       fonte_cp,
  output logic [3:0]       ula_op,
  output logic             ula_a,
  output logic [1:0]       ula_b,
  output logic             esc_reg,
  output logic             flag_imm,
  output logic             halted,
  output logic [2:0]       estado,
  output logic [CNT_W-1:0] n_instr
);

  estado_t    est, prox;
  logic [3:0] op_q;
  logic       flag_z;
  logic       pulso;
  logic       entra_parada;
  logic       incrementa;

  detector_borda u_detector (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .entrada_n(step_key_n),
    .pulso    (pulso)
  );

  assign entra_parada = (est == DECODIFICA) && (opcode == OP_HALT);
  assign incrementa   = (est == RETIRA) || entra_parada;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      est     <= BUSCA;
      op_q    <= OP_ADD;
      flag_z  <= 1'b0;
      halted  <= 1'b0;
      n_instr <= '0;
    end else begin
      est <= prox;
      if (est == DECODIFICA) op_q   <= opcode;
      if (est == EXECUTA)    flag_z <= zero;
      if (entra_parada)      halted <= 1'b1;
      if (incrementa && (n_instr != '1)) n_instr <= n_instr + 1'b1;
    end
  end

  always_comb begin
    prox = est;
    unique case (est)
      BUSCA:      prox = CARREGA_IR;
      CARREGA_IR: prox = DECODIFICA;
      DECODIFICA: begin
        if (opcode <= OP_ALU_MAX)                     prox = EXECUTA;
        else if ((opcode == OP_J) || (opcode == OP_JZ)) prox = DESVIO;
        else if (opcode == OP_HALT)                   prox = ESPERA;
        else                                          prox = RETIRA;
      end
      EXECUTA:    prox = ESCRITA;
      ESCRITA:    prox = RETIRA;
      DESVIO:     prox = RETIRA;
      RETIRA:     prox = step_mode ? ESPERA : BUSCA;
      ESPERA:     if (!halted && pulso) prox = BUSCA;
      default:    prox = BUSCA;
    endcase
  end

  // Outputs are forced idle while reset is asserted so an interrupted
  // instruction never commits a register or PC write in that cycle.
  always_comb begin
    esc_ir      = 1'b0;
    esc_cp      = 1'b0;
    esc_cond_cp = 1'b0;
    fonte_cp    = FONTE_ULA;
    ula_op      = OP_ADD;
    ula_a       = 1'b0;
    ula_b       = ULA_B_REG;
    esc_reg     = 1'b0;
    flag_imm    = 1'b0;
    if (!reset) begin
      unique case (est)
        CARREGA_IR: begin
          esc_ir = 1'b1;
          esc_cp = 1'b1;
          ula_a  = 1'b1;
          ula_b  = ULA_B_UM;
        end
        EXECUTA, ESCRITA: begin
          ula_op  = op_q;
          esc_reg = (est == ESCRITA);
          if (op_q >= OP_IMM_MIN) begin
            ula_b    = ULA_B_IMM;
            flag_imm = 1'b1;
          end
        end
        DESVIO: begin
          fonte_cp    = FONTE_IR;
          esc_cp      = (op_q == OP_J);
          esc_cond_cp = (op_q == OP_JZ);
        end
        default: ;
      endcase
    end
  end

  assign estado = est;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Directed self-checking bench for sequenciador_multiciclo with a small PC
// model standing in for the datapath.
module tb_sequenciador_multiciclo;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  opcode = 4'd0;
  logic        zero = 1'b0;
  logic        step_mode = 1'b0;
  logic        step_key_n = 1'b1;
  logic        esc_ir, esc_cp, esc_cond_cp, ula_a, esc_reg, flag_imm, halted;
  logic [1:0]  fonte_cp, ula_b;
  logic [3:0]  ula_op;
  logic [2:0]  estado;
  logic [15:0] n_instr;

  int n_verif = 0;
  int n_falhas = 0;
  int n_esp = 0;

  localparam logic [11:0] ALVO = 12'h0A0;
  logic [11:0] pc_mod;
  logic        flag_mod;

  sequenciador_multiciclo dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .opcode(opcode), .zero(zero),
    .step_mode(step_mode), .step_key_n(step_key_n),
    .esc_ir(esc_ir), .esc_cp(esc_cp), .esc_cond_cp(esc_cond_cp),
    .fonte_cp(fonte_cp), .ula_op(ula_op), .ula_a(ula_a), .ula_b(ula_b),
    .esc_reg(esc_reg), .flag_imm(flag_imm), .halted(halted),
    .estado(estado), .n_instr(n_instr)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Datapath stand-in: PC register and the ALU zero seen during EXECUTA.
  always @(posedge CLOCK_50) begin
    if (reset) begin
      pc_mod   <= 12'd0;
      flag_mod <= 1'b0;
    end else begin
      if (estado == 3'd3) flag_mod <= zero;
      if (esc_cp || (esc_cond_cp && flag_mod))
        pc_mod <= (fonte_cp == 2'b10) ? ALVO : pc_mod + 12'd1;
    end
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_verif++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: obtido %0h esperado %0h", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic roda_instr(input logic [3:0] op, input logic z, input int ciclos_esp,
                            output logic [23:0] seq);
    int n;
    logic [2:0] st;
    opcode = op;
    zero   = z;
    seq    = '0;
    n      = 0;
    do begin
      tick();
      n++;
      st  = estado;
      seq = {seq[20:0], st};
      verifica("esc_ir", esc_ir, st == 3'd1);
      verifica("esc_reg", esc_reg, st == 3'd4);
      case (st)
        3'd1: begin
          verifica("fetch_esc_cp", esc_cp, 1);
          verifica("fetch_ula_a", ula_a, 1);
          verifica("fetch_ula_b", ula_b, 2'b01);
          verifica("fetch_ula_op", ula_op, 0);
        end
        3'd3, 3'd4: begin
          verifica("exec_ula_op", ula_op, op);
          verifica("exec_ula_a", ula_a, 0);
          verifica("exec_ula_b", ula_b, (op >= 4'd6) ? 2'b10 : 2'b00);
          verifica("exec_flag_imm", flag_imm, op >= 4'd6);
        end
        3'd5: begin
          verifica("desvio_fonte", fonte_cp, 2'b10);
          verifica("desvio_esc_cp", esc_cp, op == 4'd12);
          verifica("desvio_cond", esc_cond_cp, op == 4'd11);
        end
        default: ;
      endcase
    end while (st != 3'd0 && st != 3'd7 && n < 12);
    verifica("ciclos", n, ciclos_esp);
  endtask

  initial begin
    logic [23:0] seq;
    int viol;

    tick(); tick();
    verifica("reset_estado", estado, 0);
    verifica("reset_n_instr", n_instr, 0);
    verifica("reset_halted", halted, 0);
    verifica("reset_ula_op", ula_op, 0);
    verifica("reset_enables", {esc_ir, esc_cp, esc_cond_cp, esc_reg}, 0);
    reset = 1'b0;
    verifica("busca_enables", {esc_ir, esc_cp, esc_cond_cp, esc_reg}, 0);

    roda_instr(4'd0, 1'b0, 6, seq); n_esp++;
    verifica("seq_add", seq, 24'o00123460);
    verifica("n_instr_1", n_instr, n_esp);
    verifica("pc_add", pc_mod, 12'h001);

    roda_instr(4'd6, 1'b1, 6, seq); n_esp++;
    roda_instr(4'd11, 1'b0, 5, seq); n_esp++;
    verifica("seq_jz", seq, 24'o00012560);
    verifica("pc_jz_tomado", pc_mod, ALVO);

    roda_instr(4'd0, 1'b0, 6, seq); n_esp++;
    roda_instr(4'd11, 1'b1, 5, seq); n_esp++;
    verifica("pc_jz_nao_tomado", pc_mod, ALVO + 12'd2);

    roda_instr(4'd1, 1'b1, 6, seq); n_esp++;
    roda_instr(4'd14, 1'b0, 4, seq); n_esp++;
    verifica("seq_nop", seq, 24'o00001260);
    roda_instr(4'd12, 1'b0, 5, seq); n_esp++;
    verifica("pc_j", pc_mod, ALVO);
    roda_instr(4'd11, 1'b0, 5, seq); n_esp++;
    verifica("pc_jz_flag_preservada", pc_mod, ALVO);
    verifica("n_instr_9", n_instr, n_esp);

    roda_instr(4'd13, 1'b0, 3, seq); n_esp++;
    verifica("seq_halt", seq, 24'o00000127);
    verifica("halted", halted, 1);
    verifica("n_instr_halt", n_instr, n_esp);
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      step_key_n = (i >= 20 && i < 24) ? 1'b0 : 1'b1;
      tick();
      if ({esc_ir, esc_cp, esc_cond_cp, esc_reg} != 4'b0 || n_instr != n_esp ||
          estado != 3'd7 || !halted)
        viol++;
    end
    verifica("parada_100", viol, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_esp = 0;
    verifica("pos_halt_estado", estado, 0);
    verifica("pos_halt_halted", halted, 0);
    verifica("pos_halt_n_instr", n_instr, 0);

    step_mode = 1'b1;
    roda_instr(4'd0, 1'b0, 6, seq); n_esp++;
    verifica("espera_estado", estado, 7);
    verifica("espera_halted", halted, 0);
    repeat (5) tick();
    verifica("espera_parado", estado, 7);
    step_key_n = 1'b0;
    tick(); tick();
    verifica("passo_2_ciclos", estado, 7);
    tick();
    verifica("passo_3_ciclos", estado, 0);
    step_key_n = 1'b1;
    tick(); tick(); tick();
    verifica("antes_exec", estado, 3);
    step_key_n = 1'b0;
    tick(); tick(); tick();
    step_key_n = 1'b1;
    n_esp++;
    verifica("pulso_exec_ignorado", estado, 7);
    repeat (10) tick();
    verifica("continua_espera", estado, 7);
    verifica("n_instr_passo", n_instr, n_esp);

    step_mode = 1'b0;
    step_key_n = 1'b0;
    tick(); tick(); tick();
    step_key_n = 1'b1;
    verifica("reentrada", estado, 0);
    tick(); tick(); tick(); tick();
    verifica("escrita_antes", estado, 4);
    verifica("escrita_esc_reg", esc_reg, 1);
    reset = 1'b1;
    #1;
    verifica("reset_ciclo_esc_reg", esc_reg, 0);
    tick();
    verifica("reset_meio_estado", estado, 0);
    verifica("reset_meio_esc_reg", esc_reg, 0);
    verifica("reset_meio_n_instr", n_instr, 0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: obtido sem_fim esperado fim");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sequenciador_multiciclo.md
Name: sequenciador_multiciclo

Overview:
Multicycle control FSM for the 16-bit datapath: register bank, ALU with A/B source muxes, PC source mux, and synchronous instruction memory. It sequences fetch, decode, execute and writeback/branch, drives every datapath enable and mux select, and latches the ALU zero flag for conditional jumps. A single-step debug mode holds the machine after each instruction until a KEY press.

Parameters:
OP_ADD, 4'd0, ALU op code used for PC+1 in fetch
CNT_W, 16, width of retired-instruction counter
OP_JZ, 4'd11, conditional jump opcode
OP_J, 4'd12, unconditional jump opcode
OP_HALT, 4'd13, halt opcode

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high
opcode  in  4  IR[15:12] from instruction register
zero  in  1  ALU zero output, valid in EXECUTA
step_mode  in  1  1 = single-step enabled (switch, quasi-static)
step_key_n  in  1  raw pushbutton, active-low, asynchronous
esc_ir  out  1  IR load enable
esc_cp  out  1  unconditional PC write
esc_cond_cp  out  1  PC write if zero flag
fonte_cp  out  2  PC source: 00 ALU, 10 IR[11:0]
ula_op  out  4  ALU operation
ula_a  out  1  0 regA, 1 PC
ula_b  out  2  00 regB, 01 constant 1, 10 zero-extended imm4
esc_reg  out  1  register bank write enable
flag_imm  out  1  immediate-format operand select
halted  out  1  HALT executed
estado  out  3  current state, for 7-segment debug
n_instr  out  CNT_W  retired-instruction count

Behaviour:
- Reset (synchronous, priority over everything): state BUSCA, flag_z=0, n_instr=0, halted=0. All enables (esc_*) low; selects 0; ula_op=OP_ADD. Applies mid-instruction: no register or PC write issues in the reset cycle.
- Outputs are Moore, decoded from state plus registered opcode.
- States, 3-bit encoding:
  BUSCA 0: memory addressed by PC; all enables 0.
  CARREGA_IR 1: esc_ir=1, esc_cp=1, ula_a=1, ula_b=01, ula_op=OP_ADD, fonte_cp=00 (PC<=PC+1).
  DECODIFICA 2: registers read. Next state:
    - opcode 0-10 -> EXECUTA
    - OP_J / OP_JZ -> DESVIO
    - OP_HALT -> PARADA
    - 14, 15 (NOP) -> RETIRA
  EXECUTA 3: ula_op=opcode, ula_a=0; ula_b=00 for opcodes 0-5, ula_b=10 with flag_imm=1 for 6-10. flag_z<=zero at exit. -> ESCRITA.
  ESCRITA 4: esc_reg=1, ALU operands held as in EXECUTA. -> RETIRA.
  DESVIO 5: fonte_cp=10. OP_J: esc_cp=1. OP_JZ: esc_cond_cp=1, with PC written only if the latched flag_z=1. -> RETIRA.
  RETIRA 6: n_instr++ (saturates at all-ones). -> ESPERA if step_mode=1, else BUSCA.
  ESPERA 7 (shares code with PARADA via halted): held until a step pulse -> BUSCA. A pulse arriving while not in ESPERA is discarded.
  PARADA: halted=1, all enables 0, n_instr incremented once on entry. Exits only on reset.
- Latency: ALU instr 6 cycles; J/JZ 5; NOP 4; each plus ESPERA dwell when stepping.
- flag_z is updated only by EXECUTA; jumps, NOPs and fetch preserve it.
- step_mode changing mid-instruction takes effect at the next RETIRA.
- Step pulse: step_key_n passes a 2-flop synchronizer, then falling-edge detect, giving a 1-cycle pulse. No debounce (bench drives clean edges).

Decomposition:
- Package sequenciador_pkg: state encodings, opcode constants (ALU 0-10, J, JZ, HALT), ula_b and fonte_cp select codes.
- One sub-module: detector_borda (2-flop sync + falling-edge pulse, reset to "key released").

Test Plan:
- Reset then opcode=0: states 0,1,2,3,4,6,0. esc_reg high exactly in state 4; esc_ir/esc_cp high in state 1; n_instr=1.
- opcode=6: in EXECUTA, ula_b=10, flag_imm=1, ula_op=6.
- ALU op with zero=1, then OP_JZ: esc_cond_cp=1, fonte_cp=10 in DESVIO. Repeat with zero=0 latched: esc_cond_cp=1 but no PC write (the datapath model's PC holds).
- OP_HALT: halted=1 from state 2+1 onward; all enables 0 for 100 cycles; n_instr frozen; reset clears halted and state=0.
- step_mode=1, opcode=0: FSM parks in ESPERA. A step_key_n low pulse of 3 cycles gives exactly one re-entry to BUSCA, 3 cycles after the falling edge. A pulse during EXECUTA is ignored.
- Assert reset during ESCRITA: next cycle state=0, esc_reg=0, n_instr=0.
